rv_data_ram: RTL and testbench
==============================

// Module: rv_data_ram
// PURPOSE
//   Byte-addressed, little-endian data memory for the single-cycle RISC-V core.
//   Supports byte, halfword and word stores selected by mem_ctrl.
//   Writes commit synchronously on the rising clock edge; reads are combinational.
//   Sits behind the execute stage: ALU result drives address, rs2 drives data_in.
// PARAMETERS
//   DEPTH_BYTES  1024  storage size in bytes; power of two, multiple of 4
//   AW           $clog2(DEPTH_BYTES)  internal index width (derived, not overridden)
// PORTS
//   clk       in   1   system clock; all state changes on posedge
//   rst       in   1   reset, synchronous, active-high
//   we        in   1   write enable, sampled at posedge clk
//   mem_ctrl  in   2   access size: 0=byte, 1=halfword, 2=word, 3=reserved
//   address   in   32  byte address
//   data_in   in   32  store data, LSB-aligned (byte=[7:0], half=[15:0])
//   data_out  out  32  load data, zero-extended, combinational
// BEHAVIOUR
//   - Storage: DEPTH_BYTES x 8-bit array; byte k of a word at addr A is at A+k.
//   - Index = address[AW-1:0]; upper address bits are ignored (modulo wrap).
//   - Alignment: half uses address with bit0 forced 0; word uses bits[1:0] forced 0.
//     Misaligned half/word accesses are silently aligned down; no trap.
//   - Write (posedge clk, rst=0, we=1):
//       mem_ctrl=0: mem[a]     <= data_in[7:0]
//       mem_ctrl=1: mem[a]     <= data_in[7:0], mem[a+1] <= data_in[15:8]
//       mem_ctrl=2: mem[a..a+3] <= data_in[7:0],[15:8],[23:16],[31:24]
//       mem_ctrl=3: no write
//     Bytes outside the selected lanes are unchanged.
//   - Read (combinational, independent of we):
//       mem_ctrl=0: {24'h0, mem[a]}
//       mem_ctrl=1: {16'h0, mem[a+1], mem[a]}
//       mem_ctrl=2: {mem[a+3], mem[a+2], mem[a+1], mem[a]}
//       mem_ctrl=3: 32'h0
//     Sign extension is the core's responsibility, not this block's.
//   - Read-during-write to the same address: data_out shows old contents until
//     the edge, then new contents (no write-through bypass).
//   - Reset: at posedge clk with rst=1, every byte clears to 8'h00.
//     Reset has priority over we. Afterwards data_out = 0 for any address/size.
//   - Power-up contents before the first reset are undefined (X in simulation).
//   - Latency: write visible on data_out immediately after the committing edge;
//     read latency is zero cycles.
// TESTING
//   1. Reset 1 cycle, then read word @0, @DEPTH_BYTES-4 -> data_out=32'h0.
//   2. we=1, mem_ctrl=0, addr=1, data_in=32'h12345678, one edge; read word @0
//      -> 32'h00007800; read byte @1 -> 32'h00000078.
//   3. we=1, mem_ctrl=1, addr=2, data_in=32'h12345678; read word @0
//      -> 32'h56787800; read half @2 -> 32'h00005678.
//   4. we=1, mem_ctrl=2, addr=8, data_in=32'h12345678; then byte write addr=9,
//      data_in=32'hAABBCCDD; read word @8 -> 32'h1234DD78.
//   5. mem_ctrl=1, addr=15 (misaligned), data_in=32'h0000BEEF; read word @12
//      -> 32'hBEEF0000. mem_ctrl=3, we=1 -> memory unchanged, data_out=0.
//   6. we=1 and rst=1 in the same cycle, word @0 -> memory cleared, data_out=0;
//      address DEPTH_BYTES+4 aliases to index 4.

Source files
------------

// File: rtl/rv_data_ram.sv
// Byte-addressed little-endian data memory for the single-cycle RV core.
// Byte/half/word stores commit on posedge clk; loads are combinational and zero-extended.
module rv_data_ram #(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  mem_ctrl,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]    r_mem [DEPTH_BYTES];
  logic [AW-1:0] w_base;
  logic [3:0]    w_lane_en;
  logic [AW-1:0] w_idx [4];
  logic [7:0]    w_rd_byte [4];
  logic          w_unused_addr;

  // Upper address bits only alias onto the array; they carry no information here.
  assign w_unused_addr = &{1'b0, address[31:AW]};

  // Misaligned half/word accesses are aligned down rather than trapped.
  always_comb begin
    w_base    = address[AW-1:0];
    w_lane_en = 4'b0000;
    case (mem_ctrl)
      2'd0: begin
        w_base    = address[AW-1:0];
        w_lane_en = 4'b0001;
      end
      2'd1: begin
        w_base    = {address[AW-1:1], 1'b0};
        w_lane_en = 4'b0011;
      end
      2'd2: begin
        w_base    = {address[AW-1:2], 2'b00};
        w_lane_en = 4'b1111;
      end
      default: begin
        w_base    = address[AW-1:0];
        w_lane_en = 4'b0000;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_idx[gi]            = w_base + AW'(gi);
    assign w_rd_byte[gi]        = r_mem[w_idx[gi]];
    assign data_out[8*gi +: 8]  = w_lane_en[gi] ? w_rd_byte[gi] : 8'h00;
  end

  // Reset wins over we; no bypass, so a same-cycle read sees the old bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_lane_en[k]) begin
          r_mem[w_idx[k]] <= data_in[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_data_ram.sv
// Self-checking bench for rv_data_ram: directed cases plus random traffic
// checked against a byte-array reference model through a scoreboard queue.
module tb_rv_data_ram;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  mem_ctrl;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int n_vec;
  int n_miscompare;

  logic [7:0]  model_mem [DEPTH];
  logic [31:0] exp_q [$];
  string       tag_q [$];

  rv_data_ram #(.DEPTH_BYTES(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .mem_ctrl (mem_ctrl),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  function automatic int unsigned model_base(input logic [1:0] ctrl, input logic [31:0] addr);
    int unsigned a;
    a = addr % DEPTH;
    if (ctrl == 2'd1) a = a - (a % 2);
    if (ctrl == 2'd2) a = a - (a % 4);
    return a;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] ctrl, input logic [31:0] addr);
    int unsigned a;
    a = model_base(ctrl, addr);
    case (ctrl)
      2'd0:    return {24'h0, model_mem[a]};
      2'd1:    return {16'h0, model_mem[a+1], model_mem[a]};
      2'd2:    return {model_mem[a+3], model_mem[a+2], model_mem[a+1], model_mem[a]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [1:0] ctrl, input logic [31:0] addr, input logic [31:0] d);
    int unsigned a;
    a = model_base(ctrl, addr);
    if (ctrl == 2'd0) model_mem[a] = d[7:0];
    if (ctrl == 2'd1) begin
      model_mem[a]   = d[7:0];
      model_mem[a+1] = d[15:8];
    end
    if (ctrl == 2'd2) begin
      model_mem[a]   = d[7:0];
      model_mem[a+1] = d[15:8];
      model_mem[a+2] = d[23:16];
      model_mem[a+3] = d[31:24];
    end
  endtask

  task automatic pop_check();
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miscompare++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, data_out, e);
    end
  endtask

  task automatic do_reset(input logic with_we);
    @(negedge clk);
    rst = 1'b1; we = with_we; mem_ctrl = 2'd2; address = 32'h0; data_in = 32'hFFFF_FFFF;
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] ctrl, input logic [31:0] addr, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; mem_ctrl = ctrl; address = addr; data_in = d;
    @(posedge clk);
    model_write(ctrl, addr, d);
    @(negedge clk);
    we = 1'b0;
  endtask

  // Directed read: expected value is a hand-derived constant.
  task automatic read_exp(input string tag, input logic [1:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] exp);
    @(negedge clk);
    we = 1'b0; mem_ctrl = ctrl; address = addr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    pop_check();
  endtask

  task automatic read_model(input string tag, input logic [1:0] ctrl, input logic [31:0] addr);
    read_exp(tag, ctrl, addr, model_read(ctrl, addr));
  endtask

  initial begin
    n_vec = 0; n_miscompare = 0;
    rst = 1'b0; we = 1'b0; mem_ctrl = 2'd0; address = 32'h0; data_in = 32'h0;
    repeat (2) @(posedge clk);

    do_reset(1'b0);
    read_exp("rst_word0",    2'd2, 32'h0,       32'h0);
    read_exp("rst_wordtop",  2'd2, DEPTH - 4,   32'h0);

    do_write(2'd0, 32'd1, 32'h1234_5678);
    read_exp("sb_word0",     2'd2, 32'd0,       32'h0000_7800);
    read_exp("sb_byte1",     2'd0, 32'd1,       32'h0000_0078);

    do_write(2'd1, 32'd2, 32'h1234_5678);
    read_exp("sh_word0",     2'd2, 32'd0,       32'h5678_7800);
    read_exp("sh_half2",     2'd1, 32'd2,       32'h0000_5678);

    do_write(2'd2, 32'd8, 32'h1234_5678);
    do_write(2'd0, 32'd9, 32'hAABB_CCDD);
    read_exp("sw_word8",     2'd2, 32'd8,       32'h1234_DD78);

    do_write(2'd1, 32'd15, 32'h0000_BEEF);
    read_exp("mis_half",     2'd2, 32'd12,      32'hBEEF_0000);

    do_write(2'd3, 32'd8, 32'hFFFF_FFFF);
    read_exp("rsv_read",     2'd3, 32'd8,       32'h0);
    read_exp("rsv_nowrite",  2'd2, 32'd8,       32'h1234_DD78);

    // Read-during-write: old data before the edge, new data right after it.
    @(negedge clk);
    we = 1'b1; mem_ctrl = 2'd2; address = 32'd0; data_in = 32'hCAFE_F00D;
    #1 check_eq("rdw_before", data_out, 32'h5678_7800);
    @(posedge clk);
    model_write(2'd2, 32'd0, 32'hCAFE_F00D);
    #1 check_eq("rdw_after", data_out, 32'hCAFE_F00D);
    @(negedge clk);
    we = 1'b0;

    read_exp("mis_word3",    2'd2, 32'd3,       32'hCAFE_F00D);
    read_exp("mis_half1",    2'd1, 32'd1,       32'h0000_F00D);

    do_write(2'd2, DEPTH + 4, 32'h0BAD_BEEF);
    read_exp("alias_word4",  2'd2, 32'd4,       32'h0BAD_BEEF);
    read_exp("alias_byte",   2'd0, DEPTH + 3,   32'h0000_00CA);

    do_reset(1'b1);
    read_exp("rstwe_word0",  2'd2, 32'd0,       32'h0);
    read_exp("rstwe_word4",  2'd2, 32'd4,       32'h0);
    read_exp("rstwe_word12", 2'd2, 32'd12,      32'h0);

    // Random traffic confined to a small window so reads hit written bytes.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  c;
      logic [31:0] a;
      c = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) * DEPTH) + $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) do_write(c, a, $urandom);
      else read_model($sformatf("rnd%0d", i), c, a);
    end
    for (int a = 0; a < 32; a += 4) begin
      read_model($sformatf("sweep%0d", a), 2'd2, 32'(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
